// File: rtl/piece_pkg.sv
// Shared types, base piece masks and mask helpers for the piece engine.
package piece_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSpawn    = 3'd1,
    StFall     = 3'd2,
    StLock     = 3'd3,
    StClear    = 3'd4,
    StGameOver = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CmdNop   = 2'd0,
    CmdLeft  = 2'd1,
    CmdRight = 2'd2,
    CmdRot   = 2'd3
  } cmd_e;

  // Mask bit order is {r0c0, r0c1, r1c0, r1c1}.
  localparam logic [3:0] MASK0 = 4'b1111;
  localparam logic [3:0] MASK1 = 4'b1100;
  localparam logic [3:0] MASK2 = 4'b1110;
  localparam logic [3:0] MASK3 = 4'b1000;

  localparam int unsigned MAX_CELLS = 1024;

  function automatic logic [3:0] base_mask(logic [1:0] t);
    case (t)
      2'd0:    return MASK0;
      2'd1:    return MASK1;
      2'd2:    return MASK2;
      default: return MASK3;
    endcase
  endfunction

  function automatic logic [3:0] rot_cw(logic [3:0] m);
    return {m[1], m[3], m[0], m[2]};
  endfunction

  function automatic logic [3:0] mask_of(logic [1:0] t, logic [1:0] rot);
    logic [3:0] m;
    m = base_mask(t);
    for (int i = 0; i < 3; i++) begin
      if (i < int'(rot)) m = rot_cw(m);
    end
    return m;
  endfunction

  // Overlay of a 2x2 box on a board of width cols; callers truncate to their board size.
  function automatic logic [MAX_CELLS-1:0] place(logic [3:0] m, int unsigned col,
                                                 int unsigned row, int unsigned cols);
    logic [MAX_CELLS-1:0] one;
    logic [MAX_CELLS-1:0] o;
    int unsigned          base;
    one  = {{(MAX_CELLS-1){1'b0}}, 1'b1};
    o    = '0;
    base = row * cols + col;
    if (m[3]) o = o | (one << base);
    if (m[2]) o = o | (one << (base + 1));
    if (m[1]) o = o | (one << (base + cols));
    if (m[0]) o = o | (one << (base + cols + 1));
    return o;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free-running every cycle.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [1:0] o_rnd
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign o_rnd = r_lfsr[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= SEED;
    else          r_lfsr <= {r_lfsr[6:0], w_fb};
  end

endmodule

// File: rtl/piece_engine.sv
// Falling-block game engine: board, active piece, spawn/move/fall/lock/line-clear sequencing.
module piece_engine
  import piece_pkg::*;
#(
  parameter int         COLS = 4,
  parameter int         ROWS = 8,
  parameter int         LW   = 8,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic                     clka,
  input  logic                     restart,
  input  logic                     start,
  input  logic                     tick,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd,
  output logic                     cmd_ready,
  input  logic                     spawn_sel_en,
  input  logic [1:0]               spawn_sel,
  output logic [COLS*ROWS-1:0]     board_out,
  output logic [1:0]               piece_out,
  output logic [$clog2(COLS)-1:0]  col_out,
  output logic [$clog2(ROWS)-1:0]  row_out,
  output logic [1:0]               rot_out,
  output logic [2:0]               state_out,
  output logic [LW-1:0]            lines_out,
  output logic                     locked,
  output logic                     game_over
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int NC = COLS * ROWS;

  function automatic logic [NC-1:0] overlay(logic [3:0] m, int unsigned c, int unsigned r);
    return NC'(place(m, c, r, COLS));
  endfunction

  function automatic logic hits(logic [NC-1:0] b, logic [3:0] m, int c, int r);
    if (c < 0 || c > COLS - 2 || r < 0 || r > ROWS - 2) return 1'b1;
    return |(b & overlay(m, c, r));
  endfunction

  state_e          r_state, w_state_d;
  logic [NC-1:0]   r_board, w_board_d, r_disp, w_disp_d;
  logic [1:0]      r_piece, w_piece_d, r_rot, w_rot_d;
  logic [CW-1:0]   r_col, w_col_d;
  logic [RW-1:0]   r_row, w_row_d, r_scan, w_scan_d;
  logic [LW-1:0]   r_lines, w_lines_d;
  logic            r_pend, w_pend_d, r_locked, w_locked_d;

  logic [1:0]      w_rnd, w_spawn_type;
  logic [3:0]      w_mask;
  logic [COLS-1:0] w_row_bits;
  logic            w_row_full, w_cmd_acc, w_tick_due, w_tick_blocked, w_spawn_hit;
  int              w_ci, w_ri;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .i_clk   (clka),
    .i_rst_n (restart),
    .o_rnd   (w_rnd)
  );

  assign w_spawn_type   = spawn_sel_en ? spawn_sel : w_rnd;
  assign w_mask         = mask_of(r_piece, r_rot);
  assign w_ci           = int'(r_col);
  assign w_ri           = int'(r_row);
  assign w_cmd_acc      = cmd_valid && cmd_ready;
  assign w_tick_due     = r_pend || tick;
  assign w_tick_blocked = hits(r_board, w_mask, w_ci, w_ri + 1);
  assign w_spawn_hit    = hits(r_board, base_mask(w_spawn_type), (COLS - 2) / 2, 0);
  assign w_row_bits     = COLS'(r_board >> (int'(r_scan) * COLS));
  assign w_row_full     = &w_row_bits;

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:     if (start) w_state_d = StSpawn;
      StSpawn:    w_state_d = w_spawn_hit ? StGameOver : StFall;
      StFall:     if (!w_cmd_acc && w_tick_due && w_tick_blocked) w_state_d = StLock;
      StLock:     w_state_d = StClear;
      StClear:    if (!w_row_full && r_scan == '0) w_state_d = StSpawn;
      StGameOver: w_state_d = StGameOver;
      default:    w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_board_d  = r_board;
    w_piece_d  = r_piece;
    w_col_d    = r_col;
    w_row_d    = r_row;
    w_rot_d    = r_rot;
    w_scan_d   = r_scan;
    w_lines_d  = r_lines;
    w_pend_d   = r_pend;
    w_locked_d = 1'b0;
    case (r_state)
      StSpawn: begin
        w_piece_d = w_spawn_type;
        w_col_d   = CW'((COLS - 2) / 2);
        w_row_d   = '0;
        w_rot_d   = '0;
        w_pend_d  = 1'b0;
      end
      StFall: begin
        if (w_cmd_acc) begin
          // The command wins the cycle; any tick waits for the next one.
          w_pend_d = w_tick_due;
          case (cmd_e'(cmd))
            CmdLeft:  if (!hits(r_board, w_mask, w_ci - 1, w_ri)) w_col_d = r_col - 1'b1;
            CmdRight: if (!hits(r_board, w_mask, w_ci + 1, w_ri)) w_col_d = r_col + 1'b1;
            CmdRot:   if (!hits(r_board, rot_cw(w_mask), w_ci, w_ri)) w_rot_d = r_rot + 2'd1;
            default:  ;
          endcase
        end else if (w_tick_due) begin
          w_pend_d = 1'b0;
          if (!w_tick_blocked) w_row_d = r_row + 1'b1;
        end
      end
      StLock: begin
        w_board_d  = r_board | overlay(w_mask, 32'(r_col), 32'(r_row));
        w_locked_d = 1'b1;
        w_scan_d   = RW'(ROWS - 1);
      end
      StClear: begin
        if (w_row_full) begin
          for (int r = 1; r < ROWS; r++) begin
            if (r <= int'(r_scan)) w_board_d[r*COLS +: COLS] = r_board[(r-1)*COLS +: COLS];
          end
          w_board_d[0 +: COLS] = '0;
          if (r_lines != {LW{1'b1}}) w_lines_d = r_lines + 1'b1;
        end else if (r_scan != '0) begin
          w_scan_d = r_scan - 1'b1;
        end
      end
      default: ;
    endcase
    // Active piece is shown only while it is still separate from the settled board.
    w_disp_d = w_board_d;
    if (w_state_d == StFall || w_state_d == StLock)
      w_disp_d = w_board_d | overlay(mask_of(w_piece_d, w_rot_d), 32'(w_col_d), 32'(w_row_d));
  end

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      r_board  <= '0;
      r_disp   <= '0;
      r_piece  <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_rot    <= '0;
      r_scan   <= '0;
      r_lines  <= '0;
      r_pend   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_board  <= w_board_d;
      r_disp   <= w_disp_d;
      r_piece  <= w_piece_d;
      r_col    <= w_col_d;
      r_row    <= w_row_d;
      r_rot    <= w_rot_d;
      r_scan   <= w_scan_d;
      r_lines  <= w_lines_d;
      r_pend   <= w_pend_d;
      r_locked <= w_locked_d;
    end
  end

  always_comb begin
    cmd_ready = (r_state == StFall) && !r_pend;
    game_over = (r_state == StGameOver);
  end

  assign board_out = r_disp;
  assign piece_out = r_piece;
  assign col_out   = r_col;
  assign row_out   = r_row;
  assign rot_out   = r_rot;
  assign state_out = r_state;
  assign lines_out = r_lines;
  assign locked    = r_locked;

endmodule

// File: tb/tb_piece_engine.sv
// Directed bench for piece_engine: vector table for moves/rotation plus game sequences.
module tb_piece_engine;

  localparam int COLS = 4;
  localparam int ROWS = 8;
  localparam int LW   = 2;

  logic        clka = 1'b0;
  logic        restart = 1'b0;
  logic        start = 1'b0, tick = 1'b0, cmd_valid = 1'b0, spawn_sel_en = 1'b0;
  logic [1:0]  cmd = 2'd0, spawn_sel = 2'd0;
  logic        cmd_ready, locked, game_over;
  logic [31:0] board_out;
  logic [1:0]  piece_out, col_out, rot_out, lines_out;
  logic [2:0]  row_out, state_out;

  piece_engine #(.COLS(COLS), .ROWS(ROWS), .LW(LW), .SEED(8'hA5)) dut (
    .clka         (clka),
    .restart      (restart),
    .start        (start),
    .tick         (tick),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_ready    (cmd_ready),
    .spawn_sel_en (spawn_sel_en),
    .spawn_sel    (spawn_sel),
    .board_out    (board_out),
    .piece_out    (piece_out),
    .col_out      (col_out),
    .row_out      (row_out),
    .rot_out      (rot_out),
    .state_out    (state_out),
    .lines_out    (lines_out),
    .locked       (locked),
    .game_over    (game_over)
  );

  always #5 clka = ~clka;

  // Reference LFSR; m_prev holds the value the DUT saw during the previous cycle.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clka or negedge restart) begin
    if (!restart) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cv;
    logic [1:0]  c;
    logic        tk;
    logic [31:0] col;
    logic [31:0] row;
    logic [31:0] rot;
    logic [31:0] rdy;
    logic [31:0] brd;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    restart = 1'b0; start = 1'b0; tick = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
    step();
    step();
    restart = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_board"}, board_out, 32'h0);
    chk({tag, "_piece"}, 32'(piece_out), 0);
    chk({tag, "_col"}, 32'(col_out), 0);
    chk({tag, "_row"}, 32'(row_out), 0);
    chk({tag, "_rot"}, 32'(rot_out), 0);
    chk({tag, "_state"}, 32'(state_out), 0);
    chk({tag, "_lines"}, 32'(lines_out), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_gameover"}, 32'(game_over), 0);
    chk({tag, "_ready"}, 32'(cmd_ready), 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic send(input logic [1:0] c);
    int n = 0;
    while (!cmd_ready && n < 10) begin step(); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd = c;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drop();
    int g = 0;
    while (state_out == 3'd2 && g < 20) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      g++;
    end
    chk("drop_lock", 32'(state_out), 3);
  endtask

  task automatic wait_spawn(output int n);
    n = 0;
    while (state_out != 3'd1 && n < 40) begin step(); n++; end
  endtask

  int n;

  initial begin
    // cv, cmd, tick, col, row, rot, ready, board (piece 2 starting at col 1, row 0)
    vecs[0]  = '{1'b1, 2'd1, 1'b0, 0, 0, 0, 1, 32'h13};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 0, 0, 0, 1, 32'h13};
    vecs[2]  = '{1'b1, 2'd1, 1'b0, 0, 0, 0, 1, 32'h13};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 1, 0, 0, 1, 32'h26};
    vecs[4]  = '{1'b1, 2'd2, 1'b0, 2, 0, 0, 1, 32'h4C};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 2, 0, 0, 1, 32'h4C};
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 2, 0, 0, 1, 32'h4C};
    vecs[7]  = '{1'b1, 2'd0, 1'b0, 2, 0, 0, 1, 32'h4C};
    vecs[8]  = '{1'b1, 2'd1, 1'b1, 1, 0, 0, 0, 32'h26};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 1, 1, 0, 1, 32'h260};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1, 2, 0, 1, 32'h2600};
    vecs[11] = '{1'b1, 2'd3, 1'b0, 1, 2, 1, 1, 32'h4600};
    vecs[12] = '{1'b1, 2'd3, 1'b0, 1, 2, 2, 1, 32'h6400};
    vecs[13] = '{1'b1, 2'd3, 1'b0, 1, 2, 3, 1, 32'h6200};
    vecs[14] = '{1'b1, 2'd3, 1'b0, 1, 2, 0, 1, 32'h2600};

    // Reset state, then spawn and fall of piece 0.
    #1;
    chk_reset("rst");
    do_reset();
    spawn_sel_en = 1'b1;
    spawn_sel = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("spawn_state", 32'(state_out), 1);
    step();
    chk("fall_state", 32'(state_out), 2);
    chk("fall_col", 32'(col_out), 1);
    chk("fall_board", board_out, 32'h66);
    for (int i = 0; i < 6; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    chk("fall_row6", 32'(row_out), 6);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("lock_state", 32'(state_out), 3);
    chk("lock_board", board_out, 32'h66000000);
    chk("lock_pulse_pre", 32'(locked), 0);
    step();
    chk("lock_pulse", 32'(locked), 1);
    chk("clear_board", board_out, 32'h66000000);
    step();
    chk("lock_pulse_end", 32'(locked), 0);
    step();
    wait_spawn(n);
    chk("lock_to_spawn_k0", 32'(n + 3), 9);

    // Vector table: walls, rotation, command+tick collision.
    do_reset();
    spawn_sel = 2'd2;
    start_game();
    chk("tbl_ready0", 32'(cmd_ready), 1);
    for (int i = 0; i < 15; i++) begin
      cmd_valid = vecs[i].cv;
      cmd = vecs[i].c;
      tick = vecs[i].tk;
      step();
      cmd_valid = 1'b0;
      tick = 1'b0;
      chk($sformatf("v%0d_col", i), 32'(col_out), vecs[i].col);
      chk($sformatf("v%0d_row", i), 32'(row_out), vecs[i].row);
      chk($sformatf("v%0d_rot", i), 32'(rot_out), vecs[i].rot);
      chk($sformatf("v%0d_ready", i), 32'(cmd_ready), vecs[i].rdy);
      chk($sformatf("v%0d_board", i), board_out, vecs[i].brd);
    end

    // Line clear: row 7 cols 0-1 from rotated piece 1, then piece 0 at col 2.
    do_reset();
    spawn_sel = 2'd1;
    start_game();
    send(2'd3);
    send(2'd3);
    send(2'd1);
    drop();
    spawn_sel = 2'd0;
    wait_spawn(n);
    chk("lc_spawn_k0", 32'(n), 9);
    chk("lc_board0", board_out, 32'h30000000);
    step();
    send(2'd2);
    drop();
    chk("lc_lock_board", board_out, 32'hFC000000);
    spawn_sel = 2'd1;
    wait_spawn(n);
    chk("lc_spawn_k1", 32'(n), 10);
    chk("lc_lines1", 32'(lines_out), 1);
    chk("lc_board1", board_out, 32'hC0000000);
    step();
    // Piece 1 parked at row 6 above the settled cells: rotation would overlap.
    send(2'd2);
    for (int i = 0; i < 6; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    chk("blk_row", 32'(row_out), 6);
    send(2'd3);
    chk("blk_rot", 32'(rot_out), 0);
    chk("blk_board", board_out, 32'hCC000000);
    drop();
    spawn_sel = 2'd0;
    wait_spawn(n);
    chk("lc_board2", board_out, 32'hCC000000);
    step();
    send(2'd1);
    drop();
    spawn_sel = 2'd1;
    wait_spawn(n);
    chk("lc_spawn_k2", 32'(n), 11);
    chk("lc_lines3", 32'(lines_out), 3);
    chk("lc_board3", board_out, 32'h0);
    // One more clear must saturate the 2-bit line counter.
    step();
    send(2'd3);
    send(2'd3);
    send(2'd1);
    drop();
    wait_spawn(n);
    step();
    send(2'd3);
    send(2'd3);
    send(2'd2);
    drop();
    wait_spawn(n);
    chk("sat_spawn_k1", 32'(n), 10);
    chk("sat_lines", 32'(lines_out), 3);
    chk("sat_board", board_out, 32'h0);

    // Game over: stack piece 0 in cols 1-2 until the spawn collides.
    do_reset();
    spawn_sel = 2'd0;
    start_game();
    for (int i = 0; i < 4; i++) begin
      drop();
      wait_spawn(n);
      step();
    end
    chk("go_state", 32'(state_out), 5);
    chk("go_flag", 32'(game_over), 1);
    chk("go_ready", 32'(cmd_ready), 0);
    chk("go_board", board_out, 32'h66666666);
    cmd_valid = 1'b1;
    cmd = 2'd1;
    tick = 1'b1;
    step();
    step();
    cmd_valid = 1'b0;
    tick = 1'b0;
    chk("go_col_hold", 32'(col_out), 1);
    chk("go_state_hold", 32'(state_out), 5);
    chk("go_flag_hold", 32'(game_over), 1);

    // Asynchronous reset in the middle of CLEAR.
    do_reset();
    start_game();
    drop();
    step();
    step();
    chk("mid_clear_state", 32'(state_out), 4);
    restart = 1'b0;
    #1;
    chk_reset("mid");
    step();
    restart = 1'b1;

    // LFSR-chosen spawn at two different points in the sequence.
    spawn_sel_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 3 + 4 * k; i++) step();
      start_game();
      chk($sformatf("lfsr_state%0d", k), 32'(state_out), 2);
      chk($sformatf("lfsr_piece%0d", k), 32'(piece_out), 32'(m_prev[1:0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
